// File: rtl/bus_waitstate_ram.sv
// -----------------------------------------------------------------------------
// bus_waitstate_ram
//
// Word-organised synchronous RAM used as a bus slave. It sits directly downstream
// of the multicycle core's data_memory_interface. A programmable number of wait
// states is inserted before each request is accepted, which exercises the core's
// stall and handshake path.
//
// Handshake: the master raises bus_read_enable or bus_write_enable and holds
// address, data and byte enables stable. A request is accepted on the rising
// edge where the request is high and bus_wait_req is low. For a read, the word
// appears on bus_read_data together with a single-cycle bus_valid one cycle
// after acceptance. For a write, no bus_valid is returned. bus_error pulses for
// one cycle, in the bus_valid slot, when the accepted request was out of range
// or asserted read and write at the same time.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-low reset
//   bus_address      in   byte address; bits [1:0] ignored
//   bus_write_data   in   store data, already lane-aligned
//   bus_byte_enable  in   per-byte write mask (bit i -> bits [8i+7:8i])
//   bus_read_enable  in   read request
//   bus_write_enable in   write request
//   bus_read_data    out  read response data (held until the next read)
//   bus_wait_req     out  slave not accepting this cycle
//   bus_valid        out  single-cycle read-data-valid strobe
//   bus_error        out  single-cycle error strobe
//   dbg_state        out  current FSM state (0 IDLE, 1 STALL, 2 RESP)
// -----------------------------------------------------------------------------
module bus_waitstate_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_read_data,
  output logic        bus_wait_req,
  output logic        bus_valid,
  output logic        bus_error,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  // sel_q is set when the last accepted read hit the RAM. It is cleared by
  // reset or by an out-of-range read, which forces bus_read_data to zero
  // without adding a reset to the RAM output register.
  logic        sel_q, sel_d;
  logic [31:0] ram_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          accept;
  logic          both_rw;
  logic          mem_we;
  logic          ram_re;
  logic          rd_accept;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;

  assign req     = bus_read_enable | bus_write_enable;
  assign both_rw = bus_read_enable & bus_write_enable;

  // DEPTH_WORDS is a power of two, so the offset is in range exactly when no
  // bit above the word-index field is set. An address below BASE_ADDR wraps
  // to a large offset and is caught by the same test.
  assign offset   = bus_address - BASE_ADDR;
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign word_idx = offset[AW+1:2];

  // ---------------------------------------------------------------------------
  // Next-state and handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    bus_wait_req = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WS == 4'd0) begin
            accept = 1'b1;
          end else begin
            bus_wait_req = 1'b1;
            state_d      = ST_STALL;
            cnt_d        = WS - 4'd1;
          end
        end
      end
      ST_STALL: begin
        if (cnt_q != 4'd0) begin
          bus_wait_req = 1'b1;
          cnt_d        = cnt_q - 4'd1;
        end else if (req) begin
          accept = 1'b1;
        end else begin
          // Master withdrew its request: drop back without an access.
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        // A request already pending here is taken up again in IDLE, where
        // its wait-state count starts afresh.
        bus_wait_req = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While reset is held, nothing can be accepted and the slave reports
    // that it is not stalling.
    if (!reset) begin
      accept       = 1'b0;
      bus_wait_req = 1'b0;
    end

    if (accept) begin
      state_d = (bus_read_enable && !bus_write_enable) ? ST_RESP : ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Access decode at the acceptance edge
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_accept = accept & bus_read_enable & ~bus_write_enable;
    mem_we    = accept & bus_write_enable & in_range;
    ram_re    = rd_accept & in_range;
    err_d     = accept & (~in_range | both_rw);
    sel_d     = sel_q;
    if (rd_accept) begin
      sel_d = in_range;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-port RAM. A read and a write are never accepted in the same cycle,
  // so one port is enough. The contents are deliberately not reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (mem_we) begin
      if (bus_byte_enable[0]) mem[word_idx][7:0]   <= bus_write_data[7:0];
      if (bus_byte_enable[1]) mem[word_idx][15:8]  <= bus_write_data[15:8];
      if (bus_byte_enable[2]) mem[word_idx][23:16] <= bus_write_data[23:16];
      if (bus_byte_enable[3]) mem[word_idx][31:24] <= bus_write_data[31:24];
    end
    if (ram_re) begin
      ram_q <= mem[word_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_read_data = sel_q ? ram_q : 32'h0000_0000;
  assign bus_valid     = (state_q == ST_RESP);
  assign bus_error     = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bus_waitstate_ram.sv
// Testbench for bus_waitstate_ram.
//
// Two instances are used:
//   d=0  WAIT_STATES=2, DEPTH_WORDS=256, BASE_ADDR=0x0001_0000
//   d=1  WAIT_STATES=0, DEPTH_WORDS=64,  BASE_ADDR=0
//
// Each response queue entry is {valid, error, data}.
module tb_bus_waitstate_ram;

  localparam logic [31:0] B0 = 32'h0001_0000;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] rdata [2];
  logic        wreq  [2];
  logic        vld   [2];
  logic        err   [2];
  logic [1:0]  st    [2];

  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bus_waitstate_ram #(
    .DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(B0)
  ) dut0 (
    .clock(clock), .reset(rst_n),
    .bus_address(addr[0]), .bus_write_data(wdata[0]), .bus_byte_enable(be[0]),
    .bus_read_enable(rd[0]), .bus_write_enable(wr[0]),
    .bus_read_data(rdata[0]), .bus_wait_req(wreq[0]), .bus_valid(vld[0]),
    .bus_error(err[0]), .dbg_state(st[0])
  );

  bus_waitstate_ram #(
    .DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)
  ) dut1 (
    .clock(clock), .reset(rst_n),
    .bus_address(addr[1]), .bus_write_data(wdata[1]), .bus_byte_enable(be[1]),
    .bus_read_enable(rd[1]), .bus_write_enable(wr[1]),
    .bus_read_data(rdata[1]), .bus_wait_req(wreq[1]), .bus_valid(vld[1]),
    .bus_error(err[1]), .dbg_state(st[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [33:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // One complete bus access: drive, count wait cycles, queue the expected
  // response, release the request after acceptance, then check the two
  // cycles that follow.
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input logic r, input logic w,
                        input logic ev, input logic ee, input logic [31:0] ed,
                        input string nm);
    int waits;
    bit got;
    waits = 0;
    got   = 1'b0;
    @(posedge clock); #1;
    addr[d] = a; wdata[d] = wd; be[d] = b; rd[d] = r; wr[d] = w;
    while (!got && waits < 40) begin
      @(negedge clock);
      if (!wreq[d]) got = 1'b1;
      else          waits++;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: wait_req still high after %0d cycles, required low within %0d",
               nm, waits, (d == 0) ? 2 : 0);
      rd[d] = 1'b0; wr[d] = 1'b0;
      return;
    end
    if (ev || ee) push(d, {ev, ee, ed});
    @(posedge clock); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    chk({nm, "_waits"}, 32'(waits), (d == 0) ? 32'd2 : 32'd0);
    @(negedge clock);
    chk({nm, "_valid_slot"}, {31'd0, vld[d]}, {31'd0, ev});
    chk({nm, "_error_slot"}, {31'd0, err[d]}, {31'd0, ee});
    @(negedge clock);
    chk({nm, "_valid_after"}, {30'd0, vld[d], err[d]}, 32'd0);
  endtask

  // Response monitors: every valid or error strobe must match the head
  // of the expected queue.
  always @(negedge clock) begin
    logic [33:0] e;
    if (rst_n && (vld[0] || err[0])) begin
      n_vec++;
      if (exp_q0.size() == 0) begin
        n_bad++;
        $display("FAIL resp0: got valid=%b error=%b data=%h, required no response",
                 vld[0], err[0], rdata[0]);
      end else begin
        e = exp_q0.pop_front();
        if ({vld[0], err[0]} !== e[33:32] || (e[33] && rdata[0] !== e[31:0])) begin
          n_bad++;
          $display("FAIL resp0: got valid=%b error=%b data=%h, required valid=%b error=%b data=%h",
                   vld[0], err[0], rdata[0], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [33:0] e;
    if (rst_n && (vld[1] || err[1])) begin
      n_vec++;
      if (exp_q1.size() == 0) begin
        n_bad++;
        $display("FAIL resp1: got valid=%b error=%b data=%h, required no response",
                 vld[1], err[1], rdata[1]);
      end else begin
        e = exp_q1.pop_front();
        if ({vld[1], err[1]} !== e[33:32] || (e[33] && rdata[1] !== e[31:0])) begin
          n_bad++;
          $display("FAIL resp1: got valid=%b error=%b data=%h, required valid=%b error=%b data=%h",
                   vld[1], err[1], rdata[1], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; be[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
    end

    // Reset: outputs idle, and wait_req stays low even with a request held.
    rst_n = 1'b0;
    addr[0] = B0; rd[0] = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_wait_req", {31'd0, wreq[0]}, 32'd0);
    chk("rst_valid_error", {30'd0, vld[0], err[0]}, 32'd0);
    chk("rst_read_data", rdata[0], 32'd0);
    chk("rst_state", {30'd0, st[0]}, 32'd0);
    chk("rst_dut1_outputs", {29'd0, wreq[1], vld[1], err[1]}, 32'd0);
    rd[0] = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;

    // 1. Basic write then read with two wait states.
    access(0, B0 + 32'h10, 32'hCAFEBABE, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t1_wr");
    access(0, B0 + 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFEBABE, "t1_rd");

    // 2. Byte enables.
    access(0, B0 + 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t2_wr_full");
    access(0, B0 + 32'h20, 32'h0000AA00, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t2_wr_b1");
    access(0, B0 + 32'h20, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1122AA44, "t2_rd1");
    access(0, B0 + 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t2_wr_none");
    chk("t2_read_data_hold", rdata[0], 32'h1122AA44);
    access(0, B0 + 32'h20, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1122AA44, "t2_rd2");

    // 3. Zero wait states, back-to-back reads held continuously.
    access(1, 32'h0, 32'h01010101, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t3_wr0");
    access(1, 32'h4, 32'h02020202, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t3_wr4");
    @(posedge clock); #1;
    addr[1] = 32'h0; rd[1] = 1'b1;
    @(negedge clock);
    chk("t3_c0_wait_valid", {30'd0, wreq[1], vld[1]}, 32'b00);
    push(1, {2'b10, 32'h01010101});
    @(posedge clock); #1;
    addr[1] = 32'h4;
    @(negedge clock);
    chk("t3_c1_wait_valid", {30'd0, wreq[1], vld[1]}, 32'b11);
    push(1, {2'b10, 32'h02020202});
    @(negedge clock);
    chk("t3_c2_wait_valid", {30'd0, wreq[1], vld[1]}, 32'b00);
    @(posedge clock); #1;
    rd[1] = 1'b0;
    @(negedge clock);
    chk("t3_c3_wait_valid", {30'd0, wreq[1], vld[1]}, 32'b11);
    @(negedge clock);
    chk("t3_c4_wait_valid", {30'd0, wreq[1], vld[1]}, 32'b00);

    // 4. Out-of-range accesses (above the window and just below the base).
    access(0, B0, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t4_wr_w0");
    access(0, B0 + 32'h400, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "t4_rd_oor_hi");
    chk("t4_oor_data_held_zero", rdata[0], 32'h0);
    access(0, B0 - 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "t4_rd_oor_lo");
    access(0, B0 + 32'h400, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, "t4_wr_oor");
    access(0, B0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, "t4_rd_w0");

    // 5. Read and write together: write happens, error, no valid.
    access(0, B0 + 32'h8, 32'h00000055, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, "t5_rw");
    access(0, B0 + 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000055, "t5_rd");

    // 6. Reset during the STALL of a write.
    access(0, B0 + 32'h30, 32'h00003030, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "t6_wr_old");
    access(0, B0 + 32'h30, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00003030, "t6_rd_old");
    @(posedge clock); #1;
    addr[0] = B0 + 32'h30; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF; wr[0] = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    chk("t6_in_stall", {30'd0, st[0]}, 32'd1);
    rst_n = 1'b0;
    @(negedge clock);
    chk("t6_rst_state", {30'd0, st[0]}, 32'd0);
    chk("t6_rst_wait_req", {31'd0, wreq[0]}, 32'd0);
    chk("t6_rst_valid_error", {30'd0, vld[0], err[0]}, 32'd0);
    chk("t6_rst_read_data", rdata[0], 32'd0);
    wr[0] = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("t6_post_state", {30'd0, st[0]}, 32'd0);
    chk("t6_post_outputs", {29'd0, wreq[0], vld[0], err[0]}, 32'd0);
    access(0, B0 + 32'h30, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00003030, "t6_rd_new");

    repeat (3) @(negedge clock);
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
